// File: rtl/fios_res_collector_pkg.sv
// Shared types for the FIOS result collector.
// Optional FIOS_RES_COLLECTOR_FINAL_SUB_EN adds final Montgomery subtraction.
package fios_res_collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fios_res_collector_if.sv
// Word-serial input stream and parallel valid/ready result bus.
// slave = collector side, master = multiplier/consumer side.
interface fios_res_collector_if #(
  parameter int s          = 8,
  parameter int WORD_WIDTH = 17
);
  logic                      start_i;
  logic                      res_valid_i;
  logic [WORD_WIDTH-1:0]     res_i;
  logic [WORD_WIDTH-1:0]     p_i;
  logic [s*WORD_WIDTH-1:0]   result_o;
  logic                      result_valid_o;
  logic                      result_ready_i;
  logic                      busy_o;
  logic                      err_o;

  modport slave (
    input  start_i, res_valid_i, res_i, p_i,
    input  result_ready_i,
    output result_o, result_valid_o,
    output busy_o, err_o
  );

  modport master (
    output start_i, res_valid_i, res_i, p_i,
    output result_ready_i,
    input  result_o, result_valid_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/fios_serial_sub.sv
// Word-serial subtractor a - b - borrow, borrow held across words.
// Used only with FIOS_RES_COLLECTOR_FINAL_SUB_EN.
module fios_serial_sub #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_next
);
  logic         borrow_q;
  logic [W:0]   full;

  assign full        = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_q};
  assign diff        = full[W-1:0];
  assign borrow_next = full[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        borrow_q <= 1'b0;
    else if (clear) borrow_q <= 1'b0;
    else if (en)    borrow_q <= borrow_next;
  end
endmodule

// File: rtl/fios_res_collector.sv
// Assembles the FIOS word-serial result into a parallel valid/ready word.
// FIOS_RES_COLLECTOR_FINAL_SUB_EN: conditional subtract of p on the fly.
module fios_res_collector
  import fios_res_collector_pkg::*;
#(
  parameter int s          = 8,
  parameter int WORD_WIDTH = 17
) (
  input logic                 clock_i,
  input logic                 reset_i,
  fios_res_collector_if.slave bus
);
  localparam int CW = cnt_width(s);
  localparam logic [CW-1:0] LAST = CW'(s - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [s-1:0][WORD_WIDTH-1:0] raw_q, raw_asm;
  logic [s-1:0][WORD_WIDTH-1:0] res_q, res_next;
  logic err_q, err_set;
  logic take, clear, last;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    clear   = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = COLLECT;
          clear   = 1'b1;
        end
        if (bus.res_valid_i) err_set = 1'b1;
      end
      COLLECT: begin
        // a restart discards the word of the same cycle
        if (bus.start_i) clear = 1'b1;
        else if (bus.res_valid_i) begin
          take = 1'b1;
          if (cnt_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.result_ready_i) begin
          state_d = bus.start_i ? COLLECT : IDLE;
          clear   = bus.start_i;
        end else if (bus.start_i) begin
          err_set = 1'b1;
        end
        if (bus.res_valid_i) err_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = take && (cnt_q == LAST);

  always_comb begin
    raw_asm        = raw_q;
    raw_asm[cnt_q] = bus.res_i;
  end

`ifdef FIOS_RES_COLLECTOR_FINAL_SUB_EN
  logic [s-1:0][WORD_WIDTH-1:0] dif_q, dif_asm;
  logic [WORD_WIDTH-1:0] dif_word;
  logic borrow_next;

  fios_serial_sub #(
    .W(WORD_WIDTH)
  ) u_sub (
    .clk        (clock_i),
    .rst        (reset_i),
    .en         (take),
    .clear      (clear),
    .a          (bus.res_i),
    .b          (bus.p_i),
    .diff       (dif_word),
    .borrow_next(borrow_next)
  );

  always_comb begin
    dif_asm        = dif_q;
    dif_asm[cnt_q] = dif_word;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)   dif_q <= '0;
    else if (take) dif_q[cnt_q] <= dif_word;
  end

  // final borrow set means result < p: keep the raw value
  assign res_next = borrow_next ? raw_asm : dif_asm;
`else
  assign res_next = raw_asm;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      raw_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear)     cnt_q <= '0;
      else if (last) cnt_q <= '0;
      else if (take) cnt_q <= cnt_q + 1'b1;
      if (take)    raw_q[cnt_q] <= bus.res_i;
      if (last)    res_q <= res_next;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.result_o       = res_q;
  assign bus.result_valid_o = (state_q == HOLD);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_fios_res_collector.sv
// Self-checking bench for fios_res_collector (s=4, WORD_WIDTH=17).
// Honours FIOS_RES_COLLECTOR_FINAL_SUB_EN in its reference model.
module tb_fios_res_collector;
  localparam int S = 4;
  localparam int W = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] tw[S];
  logic [W-1:0] tp[S];
  logic [127:0] held;

  always #5 clk = ~clk;

  fios_res_collector_if #(.s(S), .WORD_WIDTH(W)) bus ();

  fios_res_collector #(
    .s         (S),
    .WORD_WIDTH(W)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (bus.slave)
  );

  // Integer view of the result: word k weighs 2^(k*W)
  function automatic logic [127:0] model();
    logic [127:0] r;
    logic [127:0] m;
    r = '0;
    m = '0;
    for (int k = S - 1; k >= 0; k--) begin
      r = (r << W) | 128'(tw[k]);
      m = (m << W) | 128'(tp[k]);
    end
`ifdef FIOS_RES_COLLECTOR_FINAL_SUB_EN
    if (r >= m) r = r - m;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic strobe(input logic [W-1:0] w, input logic [W-1:0] p);
    bus.res_valid_i = 1'b1;
    bus.res_i       = w;
    bus.p_i         = p;
    step();
    bus.res_valid_i = 1'b0;
    bus.res_i       = W'($urandom);
    bus.p_i         = W'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // start, s strobes with random gaps, then check the assembled result
  task automatic collect(input string tag, input int gap_max);
    pulse_start();
    for (int k = 0; k < S; k++) begin
      repeat ($urandom_range(0, gap_max)) step();
      if (k == S - 1)
        check({tag, "_pre_valid"}, 128'(bus.result_valid_o), 128'(0));
      strobe(tw[k], tp[k]);
    end
    check({tag, "_valid"}, 128'(bus.result_valid_o), 128'(1));
    check({tag, "_result"}, 128'(bus.result_o), model());
  endtask

  task automatic rand_words(input bit with_p);
    for (int k = 0; k < S; k++) begin
      tw[k] = W'($urandom);
      tp[k] = with_p ? W'($urandom) : '0;
    end
  endtask

  task automatic handshake(input string tag);
    bus.result_ready_i = 1'b1;
    step();
    bus.result_ready_i = 1'b0;
    check({tag, "_hs_valid"}, 128'(bus.result_valid_o), 128'(0));
    check({tag, "_hs_busy"}, 128'(bus.busy_o), 128'(0));
  endtask

  initial begin
    bus.start_i        = 1'b0;
    bus.res_valid_i    = 1'b0;
    bus.res_i          = '0;
    bus.p_i            = '0;
    bus.result_ready_i = 1'b0;
    repeat (2) step();
    check("rst_result", 128'(bus.result_o), 128'(0));
    check("rst_valid", 128'(bus.result_valid_o), 128'(0));
    check("rst_busy", 128'(bus.busy_o), 128'(0));
    check("rst_err", 128'(bus.err_o), 128'(0));
    rst = 1'b0;
    step();

    // basic collect with ready held high
    tw = '{17'h1, 17'h2, 17'h3, 17'h4};
    tp = '{default: '0};
    bus.result_ready_i = 1'b1;
    collect("basic", 0);
    check("basic_busy", 128'(bus.busy_o), 128'(1));
    step();
    check("basic_idle_valid", 128'(bus.result_valid_o), 128'(0));
    check("basic_idle_busy", 128'(bus.busy_o), 128'(0));
    bus.result_ready_i = 1'b0;

    // restart mid-collection, including start with a coincident strobe
    pulse_start();
    strobe(17'h0AAAA, 17'h0);
    strobe(17'h0BBBB, 17'h0);
    bus.res_valid_i = 1'b1;
    bus.res_i       = 17'h1CCCC;
    pulse_start();
    bus.res_valid_i = 1'b0;
    tw = '{17'h5, 17'h6, 17'h7, 17'h8};
    for (int k = 0; k < S; k++) strobe(tw[k], tp[k]);
    check("restart_valid", 128'(bus.result_valid_o), 128'(1));
    check("restart_result", 128'(bus.result_o), model());
    check("restart_err", 128'(bus.err_o), 128'(0));

    // back-to-back: start coincides with the handshake
    bus.result_ready_i = 1'b1;
    bus.start_i        = 1'b1;
    step();
    bus.start_i        = 1'b0;
    bus.result_ready_i = 1'b0;
    check("b2b_valid", 128'(bus.result_valid_o), 128'(0));
    check("b2b_busy", 128'(bus.busy_o), 128'(1));
    rand_words(1'b1);
    for (int k = 0; k < S; k++) strobe(tw[k], tp[k]);
    check("b2b_result", 128'(bus.result_o), model());
    check("b2b_err", 128'(bus.err_o), 128'(0));
    handshake("b2b");

    // asynchronous reset after three strobes
    pulse_start();
    for (int k = 0; k < 3; k++) strobe(W'($urandom), W'($urandom));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_result", 128'(bus.result_o), 128'(0));
    check("mid_rst_busy", 128'(bus.busy_o), 128'(0));
    check("mid_rst_valid", 128'(bus.result_valid_o), 128'(0));
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", 128'(bus.result_valid_o), 128'(0));
    rand_words(1'b1);
    collect("post_rst", 2);
    handshake("post_rst");
    check("post_rst_err", 128'(bus.err_o), 128'(0));

    // randomized transactions with gaps and backpressure
    for (int t = 0; t < 12; t++) begin
      rand_words(1'b1);
      collect("rand", 3);
      held = 128'(bus.result_o);
      repeat ($urandom_range(0, 3)) begin
        step();
        check("rand_bp_valid", 128'(bus.result_valid_o), 128'(1));
        check("rand_bp_result", 128'(bus.result_o), held);
      end
      handshake("rand");
      repeat ($urandom_range(0, 2)) step();
    end
    check("rand_err", 128'(bus.err_o), 128'(0));

`ifdef FIOS_RES_COLLECTOR_FINAL_SUB_EN
    tw = '{17'h5, 17'h0, 17'h0, 17'h1};
    tp = '{17'h3, 17'h0, 17'h0, 17'h1};
    collect("sub_ge", 0);
    check("sub_ge_const", 128'(bus.result_o), 128'(2));
    handshake("sub_ge");
    tw = '{17'h2, 17'h0, 17'h0, 17'h1};
    collect("sub_lt", 0);
    handshake("sub_lt");
    tw = '{17'h3, 17'h0, 17'h0, 17'h1};
    collect("sub_eq", 0);
    check("sub_eq_zero", 128'(bus.result_o), 128'(0));
    handshake("sub_eq");
`endif

    // backpressure with a stray strobe in HOLD
    rand_words(1'b1);
    collect("bp", 1);
    held = 128'(bus.result_o);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        check("bp_err_before", 128'(bus.err_o), 128'(0));
        strobe(W'($urandom), W'($urandom));
      end else begin
        step();
      end
      check("bp_valid", 128'(bus.result_valid_o), 128'(1));
      check("bp_result", 128'(bus.result_o), held);
    end
    check("bp_err", 128'(bus.err_o), 128'(1));
    handshake("bp");
    check("bp_err_sticky", 128'(bus.err_o), 128'(1));

    // strobe in IDLE flags an error
    do_reset();
    check("idle_err_clear", 128'(bus.err_o), 128'(0));
    strobe(W'($urandom), W'($urandom));
    check("idle_strobe_err", 128'(bus.err_o), 128'(1));
    check("idle_strobe_busy", 128'(bus.busy_o), 128'(0));

    // start in HOLD without ready is ignored but flagged
    do_reset();
    rand_words(1'b0);
    collect("hold_start", 0);
    held = 128'(bus.result_o);
    pulse_start();
    check("hold_start_err", 128'(bus.err_o), 128'(1));
    check("hold_start_valid", 128'(bus.result_valid_o), 128'(1));
    check("hold_start_result", 128'(bus.result_o), held);
    handshake("hold_start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fios_res_collector.md
Name: fios_res_collector

Overview:
- Downstream stage of the FIOS Montgomery multiplier array.
- Captures the word-serial result stream (RES_o of the multiplier, one WORD_WIDTH-bit word per strobe, least significant word first, s words per multiplication).
- Assembles the words into a parallel s*WORD_WIDTH result and presents it on a valid/ready handshake to the consumer (e.g. exponentiation controller or host interface).
- Optionally performs the final Montgomery conditional subtraction on the fly.

Parameters:
- s, 8, number of words per operand/result.
- WORD_WIDTH, 17, bits per result word; words arrive normalized (no inter-word carry).

Ports:
- clock_i  in  1  system clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse from the multiplier controller at the start of a multiplication.
- res_valid_i  in  1  strobe: res_i holds the next result word this cycle.
- res_i  in  WORD_WIDTH  result word from the multiplier (RES_o).
- p_i  in  WORD_WIDTH  modulus word, aligned with res_i/res_valid_i; used only with FINAL_SUB_EN, ignored otherwise.
- result_o  out  s*WORD_WIDTH  assembled result; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- result_valid_o  out  1  result_o is valid and stable.
- result_ready_i  in  1  consumer accepts result_o.
- busy_o  out  1  high in COLLECT and HOLD.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, active-high): state=IDLE; word counter=0; result_o=0; result_valid_o=0; busy_o=0; err_o=0; borrow=0.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - start_i -> COLLECT; counter cleared; borrow cleared.
  - res_valid_i in IDLE is ignored and sets err_o.
- COLLECT:
  - Each res_valid_i writes res_i into word slot [counter]; counter increments.
  - On the strobe with counter==s-1 -> HOLD. result_valid_o=1 on the following cycle, so latency is 1 clock from the last strobe.
  - start_i in COLLECT (with or without res_valid_i) restarts: counter=0, borrow=0, the word in that cycle is discarded, and err_o is NOT set.
- HOLD:
  - result_valid_o=1; result_o stable until handshake.
  - result_valid_o && result_ready_i -> IDLE and result_valid_o=0 next cycle.
  - start_i together with result_ready_i: handshake completes and the block goes directly to COLLECT.
  - start_i without result_ready_i: ignored, err_o set.
  - res_valid_i in HOLD: word dropped, err_o set.
- Counter: width $clog2(s) (min 1); never wraps past s-1, because the transition to HOLD occurs at s-1.
- result_ready_i in IDLE/COLLECT: no effect.
- err_o clears only on reset.
- Reset asserted mid-collection discards all partial words; no valid is ever issued for them.

Optional Feature:
- Macro: FIOS_RES_COLLECTOR_FINAL_SUB_EN.
- Enabled:
  - Per strobe compute {b', d} = res_i - p_i - borrow (WORD_WIDTH+1 bits).
  - Store d in a parallel difference buffer; update the borrow register to b'.
  - At the transition to HOLD, the final borrow selects the output:
    - borrow==0 (result >= p): result_o = difference buffer.
    - borrow==1: result_o = raw buffer.
  - The selection is registered, so latency remains 1 cycle.
- Disabled: no difference buffer, no borrow logic, p_i unused; result_o = raw buffer.

Decomposition:
- Package fios_res_collector_pkg:
  - state enum typedef (IDLE, COLLECT, HOLD).
  - function computing counter width from s.
- One sub-module, fios_serial_sub: registered word-serial subtractor with borrow (inputs en, clear, a, b; outputs diff word and borrow). Instantiated only under the macro.

Test Plan (s=4, WORD_WIDTH=17):
- Basic collect:
  - Stimulus: start; strobes with 0x00001, 0x00002, 0x00003, 0x00004; result_ready_i=1.
  - Response: result_valid_o high exactly 1 cycle after the 4th strobe; result_o words[0..3] = 1,2,3,4; back to IDLE the next cycle.
- Backpressure:
  - Stimulus: result_ready_i=0 for 10 cycles after completion.
  - Response: result_valid_o and result_o held constant; an extra res_valid_i in HOLD sets err_o and leaves result_o unchanged.
- Restart:
  - Stimulus: start, 2 words (0x0AAAA, 0x0BBBB), start again, then 4 words 5,6,7,8.
  - Response: result_o = 5,6,7,8; err_o=0.
- Reset mid-operation:
  - Stimulus: assert reset_i asynchronously after 3 strobes.
  - Response: all outputs 0 immediately; a following start plus 4 words yields a correct result.
- Back-to-back:
  - Stimulus: start coincident with the result_ready_i handshake in HOLD.
  - Response: next result collected with no lost word.
- With FINAL_SUB_EN:
  - Case 1: res words 5,0,0,1 with p words 3,0,0,1 -> result_o = 2,0,0,0.
  - Case 2: res words 2,0,0,1 with p 3,0,0,1 -> result_o = 2,0,0,1 (unchanged).
  - Case 3: res == p -> result_o all zero.
